// File: rtl/mem_bus_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_bus_pkg                                                              |
// | Shared encodings for the data-memory bus arbiter and response pipe.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package mem_bus_pkg;

    localparam logic [1:0] BANK_DATA = 2'd0;
    localparam logic [1:0] BANK_VGA  = 2'd1;
    localparam logic [1:0] BANK_IO   = 2'd2;
    localparam logic [1:0] BANK_NONE = 2'd3;

    localparam logic OWN_C = 1'b0;
    localparam logic OWN_D = 1'b1;

    typedef enum logic [0:0] {
        ARB    = 1'b0,
        DBURST = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic       valid;
        logic       is_read;
        logic       owner;
        logic [1:0] bank;
    } rsp_tag_t;

    // BANK_NONE maps to no enable so the command is accepted but touches nothing.
    function automatic logic [2:0] bank_onehot(input logic [1:0] bank);
        logic [2:0] oh;
        case (bank)
            BANK_DATA: oh = 3'b001;
            BANK_VGA:  oh = 3'b010;
            BANK_IO:   oh = 3'b100;
            default:   oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_bus_rsp_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_bus_rsp_pipe                                                         |
// | Two-stage tag pipeline producing read-valid and bank-muxed read data.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mem_bus_rsp_pipe
    import mem_bus_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid_i,
    input  logic              issue_read_i,
    input  logic              issue_owner_i,
    input  logic [1:0]        issue_bank_i,
    input  logic [DATA_W-1:0] data_rdata_i,
    input  logic [DATA_W-1:0] vga_rdata_i,
    output logic              c_rvalid_o,
    output logic [DATA_W-1:0] c_rdata_o,
    output logic              d_rvalid_o,
    output logic [DATA_W-1:0] d_rdata_o
);

    rsp_tag_t          s1_d;
    rsp_tag_t          s1_q;
    rsp_tag_t          s2_q;
    logic              rsp_fire;
    logic [DATA_W-1:0] rd_mux;

    assign s1_d = '{valid:   issue_valid_i,
                    is_read: issue_read_i,
                    owner:   issue_owner_i,
                    bank:    issue_bank_i};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s1_q;
        end
    end

    // Bank read data arrives one cycle after the enable, aligned with stage 2.
    always_comb begin
        rd_mux = '0;
        case (s2_q.bank)
            BANK_DATA: rd_mux = data_rdata_i;
            BANK_VGA:  rd_mux = vga_rdata_i;
            default:   rd_mux = '0;
        endcase
    end

    assign rsp_fire   = s2_q.valid & s2_q.is_read;
    assign c_rvalid_o = rsp_fire & (s2_q.owner == OWN_C);
    assign d_rvalid_o = rsp_fire & (s2_q.owner == OWN_D);
    assign c_rdata_o  = c_rvalid_o ? rd_mux : '0;
    assign d_rdata_o  = d_rvalid_o ? rd_mux : '0;

endmodule
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_bus_arbiter                                                          |
// | CPU-priority data bus arbiter with DMA anti-starvation and bursts.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W     = 11,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int BURST_MAX  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c_req,
    input  logic [1:0]        c_bank,
    input  logic [3:0]        c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,
    input  logic              d_req,
    input  logic [1:0]        d_bank,
    input  logic [3:0]        d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic              d_burst,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [2:0]        mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] data_rdata,
    input  logic [DATA_W-1:0] vga_rdata
);

    localparam int              SW         = $clog2(STARVE_MAX + 1);
    localparam int              BW         = $clog2(BURST_MAX + 1);
    localparam logic [SW-1:0]   STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [BW-1:0]   BURST_LIM  = BW'(BURST_MAX);

    arb_state_e        state_q;
    arb_state_e        state_d;
    logic [SW-1:0]     starve_q;
    logic [SW-1:0]     starve_d;
    logic [BW-1:0]     burst_q;
    logic [BW-1:0]     burst_d;
    logic              c_win;
    logic              d_win;
    logic              any_gnt;
    logic [1:0]        sel_bank;
    logic [3:0]        sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    always_comb begin
        state_d = state_q;
        burst_d = burst_q;
        c_win   = 1'b0;
        d_win   = 1'b0;
        if (state_q == DBURST && d_req && d_burst && burst_q < BURST_LIM) begin
            d_win   = 1'b1;
            burst_d = burst_q + BW'(1);
        end else begin
            // Normal arbitration, also used on the cycle a burst ends.
            if (c_req && d_req) begin
                if (starve_q == STARVE_LIM &&
                    !(state_q == DBURST && burst_q == BURST_LIM)) begin
                    d_win = 1'b1;
                end else begin
                    c_win = 1'b1;
                end
            end else if (c_req) begin
                c_win = 1'b1;
            end else if (d_req) begin
                d_win = 1'b1;
            end
            if (d_win && d_burst) begin
                state_d = DBURST;
                burst_d = BW'(1);
            end else begin
                state_d = ARB;
                burst_d = '0;
            end
        end
    end

    // Grants are suppressed while reset is held so every output reads zero.
    assign c_gnt   = c_win & rst;
    assign d_gnt   = d_win & rst;
    assign any_gnt = c_gnt | d_gnt;

    always_comb begin
        starve_d = starve_q;
        if (!d_req || d_gnt) begin
            starve_d = '0;
        end else if (starve_q < STARVE_LIM) begin
            starve_d = starve_q + SW'(1);
        end
    end

    always_comb begin
        sel_bank  = c_bank;
        sel_we    = c_we;
        sel_addr  = c_addr;
        sel_wdata = c_wdata;
        if (d_gnt) begin
            sel_bank  = d_bank;
            sel_we    = d_we;
            sel_addr  = d_addr;
            sel_wdata = d_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ARB;
            starve_q  <= '0;
            burst_q   <= '0;
            mem_en    <= '0;
            mem_we    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            burst_q  <= burst_d;
            mem_en   <= any_gnt ? bank_onehot(sel_bank) : 3'b000;
            mem_we   <= any_gnt ? sel_we : 4'b0000;
            if (any_gnt) begin
                mem_addr  <= sel_addr;
                mem_wdata <= sel_wdata;
            end
        end
    end

    mem_bus_rsp_pipe #(
        .DATA_W (DATA_W)
    ) u_rsp_pipe (
        .clk           (clk),
        .rst           (rst),
        .issue_valid_i (any_gnt),
        .issue_read_i  (sel_we == 4'b0000),
        .issue_owner_i (d_gnt ? OWN_D : OWN_C),
        .issue_bank_i  (sel_bank),
        .data_rdata_i  (data_rdata),
        .vga_rdata_i   (vga_rdata),
        .c_rvalid_o    (c_rvalid),
        .c_rdata_o     (c_rdata),
        .d_rvalid_o    (d_rvalid),
        .d_rdata_o     (d_rdata)
    );

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_bus_arbiter                                                       |
// | Directed scoreboard bench for the data-memory bus arbiter.               |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_mem_bus_arbiter;

    localparam int AW = 11;
    localparam int DW = 32;

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          c_req, d_req, d_burst;
    logic [1:0]    c_bank, d_bank;
    logic [3:0]    c_we, d_we;
    logic [AW-1:0] c_addr, d_addr;
    logic [DW-1:0] c_wdata, d_wdata;
    logic          c_gnt, d_gnt, c_rvalid, d_rvalid;
    logic [DW-1:0] c_rdata, d_rdata;
    logic [2:0]    mem_en;
    logic [3:0]    mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] data_rdata = '0;
    logic [DW-1:0] vga_rdata  = '0;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    exp_t          qc[$];
    exp_t          qd[$];
    logic [2:0]    exp_en, nen;
    logic [3:0]    exp_we, nwe;
    logic [AW-1:0] exp_addr, naddr;
    logic [DW-1:0] exp_wd, nwd;

    always #5 clk = ~clk;

    mem_bus_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(4), .BURST_MAX(8)
    ) dut (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_bank(c_bank), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .d_req(d_req), .d_bank(d_bank), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_burst(d_burst), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .data_rdata(data_rdata), .vga_rdata(vga_rdata)
    );

    function automatic logic [DW-1:0] dmem_f(input logic [AW-1:0] a);
        return 32'hDEADBEEF ^ {21'd0, a ^ 11'h010};
    endfunction

    function automatic logic [DW-1:0] vmem_g(input logic [AW-1:0] a);
        return {16'hC0DE, 5'd0, a};
    endfunction

    function automatic logic [DW-1:0] rd_model(input logic [1:0] b, input logic [AW-1:0] a);
        if (b == 2'd0) return dmem_f(a);
        if (b == 2'd1) return vmem_g(a);
        return '0;
    endfunction

    function automatic logic [2:0] en_model(input logic [1:0] b);
        if (b == 2'd0) return 3'b001;
        if (b == 2'd1) return 3'b010;
        if (b == 2'd2) return 3'b100;
        return 3'b000;
    endfunction

    // Bank memories: read data appears the cycle after the enable, junk otherwise.
    always @(posedge clk) begin
        data_rdata <= mem_en[0] ? dmem_f(mem_addr) : 32'h5A5A5A5A;
        vga_rdata  <= mem_en[1] ? vmem_g(mem_addr) : 32'hA5A5A5A5;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_c(input logic req, input logic [1:0] bank, input logic [3:0] we,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        c_req = req; c_bank = bank; c_we = we; c_addr = addr; c_wdata = wd;
    endtask

    task automatic set_d(input logic req, input logic burst, input logic [1:0] bank,
                         input logic [3:0] we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        d_req = req; d_burst = burst; d_bank = bank; d_we = we; d_addr = addr; d_wdata = wd;
    endtask

    task automatic clear_exp();
        exp_en = '0; exp_we = '0; exp_addr = '0; exp_wd = '0;
        qc.delete();
        qd.delete();
    endtask

    // One bus cycle: check registered outputs and responses, check grants,
    // then queue what the granted command must produce later.
    task automatic step(input logic ec, input logic ed, input string tag);
        logic ecv, edv;
        @(negedge clk);
        check({tag, "/mem_en"},    64'(mem_en),    64'(exp_en));
        check({tag, "/mem_we"},    64'(mem_we),    64'(exp_we));
        check({tag, "/mem_addr"},  64'(mem_addr),  64'(exp_addr));
        check({tag, "/mem_wdata"}, 64'(mem_wdata), 64'(exp_wd));
        ecv = (qc.size() > 0) && (qc[0].due == cyc);
        edv = (qd.size() > 0) && (qd[0].due == cyc);
        check({tag, "/c_rvalid"}, 64'(c_rvalid), 64'(ecv));
        check({tag, "/d_rvalid"}, 64'(d_rvalid), 64'(edv));
        if (ecv) check({tag, "/c_rdata"}, 64'(c_rdata), 64'(qc[0].data));
        if (edv) check({tag, "/d_rdata"}, 64'(d_rdata), 64'(qd[0].data));
        if (qc.size() > 0 && qc[0].due <= cyc) void'(qc.pop_front());
        if (qd.size() > 0 && qd[0].due <= cyc) void'(qd.pop_front());
        check({tag, "/c_gnt"}, 64'(c_gnt), 64'(ec));
        check({tag, "/d_gnt"}, 64'(d_gnt), 64'(ed));
        nen = '0; nwe = '0; naddr = exp_addr; nwd = exp_wd;
        if (ec) begin
            nen = en_model(c_bank); nwe = c_we; naddr = c_addr; nwd = c_wdata;
            if (c_we == 4'b0000) qc.push_back('{cyc + 2, rd_model(c_bank, c_addr)});
        end else if (ed) begin
            nen = en_model(d_bank); nwe = d_we; naddr = d_addr; nwd = d_wdata;
            if (d_we == 4'b0000) qd.push_back('{cyc + 2, rd_model(d_bank, d_addr)});
        end
        @(posedge clk);
        #1;
        cyc++;
        exp_en = nen; exp_we = nwe; exp_addr = naddr; exp_wd = nwd;
    endtask

    task automatic idle();
        set_c(1'b0, 2'd0, 4'd0, '0, '0);
        set_d(1'b0, 1'b0, 2'd0, 4'd0, '0, '0);
    endtask

    initial begin
        idle();
        rst = 1'b1;
        #2 rst = 1'b0;
        clear_exp();
        @(posedge clk);
        #1;

        // Reset state: requests held but no grants and all outputs zero.
        set_c(1'b1, 2'd0, 4'd0, 11'h001, '0);
        set_d(1'b1, 1'b0, 2'd1, 4'd0, 11'h002, '0);
        step(1'b0, 1'b0, "reset0");
        step(1'b0, 1'b0, "reset1");
        check("reset/c_rdata", 64'(c_rdata), 64'd0);
        check("reset/d_rdata", 64'(d_rdata), 64'd0);
        idle();
        rst = 1'b1;
        step(1'b0, 1'b0, "post_reset");

        // CPU read from DataMem.
        set_c(1'b1, 2'd0, 4'd0, 11'h010, '0);
        step(1'b1, 1'b0, "c_read");
        idle();
        step(1'b0, 1'b0, "c_read_n1");
        step(1'b0, 1'b0, "c_read_n2");
        step(1'b0, 1'b0, "c_read_n3");

        // Reset lands one cycle after a read grant: the read never completes.
        set_c(1'b1, 2'd0, 4'd0, 11'h020, '0);
        step(1'b1, 1'b0, "rst_mid_gnt");
        rst = 1'b0;
        #1;
        check("rst_mid/mem_en_async", 64'(mem_en), 64'd0);
        clear_exp();
        step(1'b0, 1'b0, "rst_mid0");
        step(1'b0, 1'b0, "rst_mid1");
        step(1'b0, 1'b0, "rst_mid2");
        check("rst_mid/c_rdata", 64'(c_rdata), 64'd0);
        idle();
        rst = 1'b1;
        step(1'b0, 1'b0, "rst_mid_rel");

        // Both requesting without burst: CCCCD repeating.
        set_c(1'b1, 2'd0, 4'd0, 11'h033, '0);
        set_d(1'b1, 1'b0, 2'd1, 4'd0, 11'h044, '0);
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) step(1'b1, 1'b0, "starve_c");
            step(1'b0, 1'b1, "starve_d");
        end
        idle();
        step(1'b0, 1'b0, "starve_idle0");
        step(1'b0, 1'b0, "starve_idle1");

        // DMA burst against a waiting CPU: starvation win then 8 locked beats.
        set_c(1'b1, 2'd1, 4'd0, 11'h055, '0);
        set_d(1'b1, 1'b1, 2'd0, 4'hF, 11'h100, 32'h1111_0000);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, "burst_c_pre");
        for (int i = 0; i < 8; i++) begin
            d_addr  = 11'h100 + 11'(i);
            d_wdata = 32'h1111_0000 + 32'(i);
            step(1'b0, 1'b1, "burst_d");
        end
        step(1'b1, 1'b0, "burst_c_post");
        idle();
        step(1'b0, 1'b0, "burst_idle0");
        step(1'b0, 1'b0, "burst_idle1");
        step(1'b0, 1'b0, "burst_idle2");

        // DMA reads I/O bank then unmapped bank back-to-back.
        set_d(1'b1, 1'b0, 2'd2, 4'd0, 11'h200, '0);
        step(1'b0, 1'b1, "d_io");
        set_d(1'b1, 1'b0, 2'd3, 4'd0, 11'h201, '0);
        step(1'b0, 1'b1, "d_none");
        idle();
        step(1'b0, 1'b0, "d_io_n1");
        step(1'b0, 1'b0, "d_io_n2");
        step(1'b0, 1'b0, "d_io_n3");

        // CPU partial write to the VGA card: no read response.
        set_c(1'b1, 2'd1, 4'b0011, 11'h0AB, 32'hCAFE_F00D);
        step(1'b1, 1'b0, "c_write");
        idle();
        step(1'b0, 1'b0, "c_write_n1");
        step(1'b0, 1'b0, "c_write_n2");
        step(1'b0, 1'b0, "c_write_n3");

        // DMA alone past BURST_MAX, CPU locked out mid-burst, then burst dropped.
        set_d(1'b1, 1'b1, 2'd1, 4'd0, 11'h300, '0);
        for (int i = 0; i < 10; i++) begin
            d_addr = 11'h300 + 11'(i);
            step(1'b0, 1'b1, "dlong");
        end
        set_c(1'b1, 2'd0, 4'd0, 11'h07F, '0);
        step(1'b0, 1'b1, "dlong_c_locked");
        d_burst = 1'b0;
        step(1'b1, 1'b0, "dlong_exit_c");
        c_req = 1'b0;
        step(1'b0, 1'b1, "dlong_exit_d");
        idle();
        step(1'b0, 1'b0, "dlong_n1");
        step(1'b0, 1'b0, "dlong_n2");
        step(1'b0, 1'b0, "dlong_n3");

        check("end/c_queue_empty", 64'(qc.size()), 64'd0);
        check("end/d_queue_empty", 64'(qd.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single data-memory bus between two requesters: the CPU load/store path (port C) and a DMA/blit engine (port D). The bus covers DataMem, VGATextCard and the I/O bank.
- Sits between MemDecoder/MemWriteDataEncoder and the memory banks, which it drives with registered commands.
- Returns read data to the winner a fixed two cycles after grant.
- Arbitration is CPU-priority with a DMA anti-starvation counter and bounded DMA bursts. CPU stalls on !c_gnt.

Parameters:
- ADDR_W, 11, word address width (physical byte address [12:2])
- DATA_W, 32, data width
- STARVE_MAX, 4, consecutive denied DMA cycles before DMA is forced to win
- BURST_MAX, 8, maximum beats in one locked DMA burst

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- c_req  in  1  CPU request; held with fields stable until c_gnt
- c_bank  in  2  0 data, 1 vga, 2 io, 3 none
- c_we  in  4  byte write enables; 0 means read
- c_addr  in  ADDR_W  word address
- c_wdata  in  DATA_W  write data
- c_gnt  out  1  request accepted this cycle
- c_rvalid  out  1  read data valid
- c_rdata  out  DATA_W  read data
- d_req, d_bank, d_we, d_addr, d_wdata, d_gnt, d_rvalid, d_rdata  same as the C-port signals, for DMA
- d_burst  in  1  DMA requests bus lock for consecutive beats
- mem_en  out  3  one-hot bank enable (bit0 data, bit1 vga, bit2 io), registered
- mem_we  out  4  registered byte enables
- mem_addr  out  ADDR_W  registered address
- mem_wdata  out  DATA_W  registered write data
- data_rdata  in  DATA_W  DataMem read data, valid one cycle after mem_en
- vga_rdata  in  DATA_W  VGATextCard read data, same timing as data_rdata

Behaviour:
- Reset (rst=0, async): all outputs 0, FSM=ARB, starve counter=0, burst counter=0, in-flight read tags cleared; no rvalid is emitted for a read in flight at reset.
- Grant signals are combinational from the current requests and state. At most one of c_gnt and d_gnt is high per cycle; a grant is only given to a requester whose req is high.
- Cycle N: grant. Cycle N+1: mem_* outputs carry the granted command. Cycle N+2: for reads only (we==0), rvalid is high for one cycle to the owner, with rdata muxed by the bank captured at issue: bank0 data_rdata, bank1 vga_rdata, bank2/3 return 0.
- Write latency is grant only; no rvalid is generated for writes.
- Back-to-back grants are allowed every cycle; the pipeline is fully overlapped.
- When no grant is given, mem_en=0 in the next cycle and mem_we=0. mem_addr and mem_wdata hold their previous values.
- Bank 3 is accepted (gnt given) but issues mem_en=0; a read to bank 3 still returns rvalid with 0.
- FSM state ARB:
  - Only C requests: C wins.
  - Only D requests: D wins.
  - Both request: C wins, unless starve==STARVE_MAX, in which case D wins.
  - If D wins with d_burst=1, the FSM moves to DBURST and burst=1.
- FSM state DBURST:
  - While d_req and d_burst are high and burst<BURST_MAX: D is granted, burst++ per beat, and C is denied regardless.
  - Exit to ARB, with burst=0, when d_req=0, or d_burst=0, or burst==BURST_MAX. In the exit cycle the request is arbitrated as in ARB, except D cannot win on the cycle burst==BURST_MAX while C requests.
- Starve counter:
  - Increments (saturating at STARVE_MAX) on each cycle with d_req=1 and d_gnt=0.
  - Clears on d_gnt or d_req=0.
- The CPU sees no ordering hazard because it holds c_req until granted and waits for c_rvalid.

Decomposition:
- Shared package mem_bus_pkg holds:
  - bank encodings BANK_DATA=0, BANK_VGA=1, BANK_IO=2, BANK_NONE=3
  - FSM enum {ARB, DBURST}
  - owner id constants OWN_C=0, OWN_D=1
- One natural sub-module, mem_bus_rsp_pipe: the two-stage tag pipeline (valid, owner, bank, is_read) that generates rvalid and the rdata mux.

Test Plan:
- Reset asserted mid-read (grant at N, rst low at N+1) -> no c_rvalid ever, mem_en=0 immediately, all outputs 0 until release.
- CPU read only: c_req=1, bank0, addr 0x010, data_rdata=0xDEADBEEF -> c_gnt at N, mem_en=3'b001 and mem_addr=0x010 at N+1, c_rvalid with c_rdata=0xDEADBEEF at N+2.
- Both requesting continuously, d_burst=0 -> c_gnt for 4 cycles, d_gnt on the 5th, pattern repeats (CCCCD).
- DMA burst: d_req=d_burst=1 with C also requesting -> 8 consecutive d_gnt beats after starvation win, then c_gnt the next cycle.
- Read bank2 and bank3 back-to-back from D -> d_rvalid on two consecutive cycles, d_rdata=0 both, mem_en=3'b100 then 3'b000.
- CPU write with we=4'b0011 to bank1 -> mem_en=3'b010, mem_we=4'b0011 at N+1, no c_rvalid.
